canny_edge: RTL and testbench
=============================

CANNY_EDGE -- requirements
Module: canny_edge

Interface
REQ-001 Parameters, one per line (name, default, meaning); all parameters SHALL be fixed at elaboration:
- IMG_W, 512: image columns.
- IMG_H, 512: image rows.
- THRESH, 11'd100: edge threshold.
REQ-002 Ports, one per line (name, direction, width, meaning); the single clock is clk, and reset n_rst is asynchronous and active-low:
- clk, in, 1: clock.
- n_rst, in, 1: async active-low reset.
- start, in, 1: begin frame (level, sampled in IDLE).
- error, out, 1: sticky protocol-error flag.
- read_enable_r, out, 1: read enable shared by all nine read SRAMs.
- mem_init_r, in, 1: host is loading the read SRAMs (monitor only).
- add_a..add_i, out, 19 each: addresses of the 3x3 window (a b c / d e f / g h i, e = centre).
- read_a..read_i, in, 8 each: unsigned pixel data, valid in the same cycle as the address.
- write_enable_w, out, 1: result write strobe.
- mem_clr_w, out, 1: tied 0.
- mem_dump_w, in, 1: host is dumping the write SRAM (monitor only).
- write_address, out, 18: result address.
- write_data, out, 8: result pixel.

Function
REQ-003 The FSM SHALL have states IDLE, RUN, FLUSH and DONE:
- IDLE->RUN on start=1.
- RUN->FLUSH after the pixel (IMG_H-1, IMG_W-1) is issued.
- FLUSH->DONE after 4 cycles.
- DONE->IDLE when start=0.
REQ-004 In RUN, one centre pixel (r,c) SHALL be issued per cycle in row-major order, starting at (0,0) on the first RUN cycle.
REQ-005 For an interior centre, the window addresses SHALL be the row-major neighbours, zero-extended to 19 bits. Centre address = r*IMG_W+c; a = centre-IMG_W-1; b = centre-IMG_W; c = centre-IMG_W+1; d = centre-1; f = centre+1; g = centre+IMG_W-1; h = centre+IMG_W; i = centre+IMG_W+1.
REQ-006 Border centre (r or c equal to 0 or max): all nine addresses SHALL equal the centre address, and a border flag SHALL travel down the pipeline.
REQ-007 read_enable_r SHALL be 1 exactly in RUN.
REQ-008 Stage 1 SHALL register the nine pixels, the centre address and the border flag.
REQ-009 Stage 2 SHALL compute Sobel gradients as signed 11-bit values:
- Gx = (c+2f+i)-(a+2d+g).
- Gy = (g+2h+i)-(a+2b+c).
REQ-010 Stage 3 SHALL compute mag = |Gx|+|Gy| as 11-bit unsigned (max 2040, no overflow).
REQ-011 Stage 4 SHALL register write_data = 8'hFF if mag >= THRESH and the border flag = 0, else 8'h00. It SHALL also register write_address = the centre address truncated to 18 bits, and write_enable_w = valid.
REQ-012 Latency: the result for a pixel issued in cycle t SHALL appear on the write port in cycle t+4, with exactly one write per pixel and IMG_W*IMG_H writes per frame.
REQ-013 start held high for several cycles SHALL launch exactly one frame, and start=1 while not in IDLE SHALL be ignored.
REQ-014 error SHALL be set when mem_dump_w=1 or mem_init_r=1 while the FSM is in RUN or FLUSH; it SHALL stay set until reset.
REQ-015 Outside RUN and FLUSH, write_enable_w SHALL be 0 and the pipeline valid bits SHALL be 0.

Reset
REQ-016 On n_rst=0, asynchronously:
- State = IDLE.
- Counters and pipeline registers = 0.
- Outputs error, read_enable_r, write_enable_w, mem_clr_w, add_a..add_i, write_address and write_data = 0.
REQ-017 Reset mid-frame SHALL abort the frame with no further writes; a new start SHALL restart at (0,0).

Structure
REQ-018 Package canny_pkg SHALL hold the state enum, IMG_W/IMG_H/THRESH defaults, and the pixel, gradient and magnitude width constants.
REQ-019 The stage-2 arithmetic SHALL be a sub-module sobel_3x3: nine 8-bit inputs in, signed Gx and Gy out, purely combinational.

Verification
REQ-020 Uniform image of all 8'd128, start pulsed for 3 cycles -> exactly 262144 writes, all data 8'h00, error=0.
REQ-021 Vertical step (columns 0..255 = 0, columns 256..511 = 255) -> 8'hFF at columns 255 and 256 for rows 1..510, 8'h00 elsewhere including all borders.
REQ-022 Latency: first RUN cycle at T -> first write_enable_w at T+4 with write_address=0 and write_data=0; last write at T+262147.
REQ-023 mem_dump_w=1 for 1 cycle mid-RUN -> error rises the next cycle and stays 1 until n_rst=0.
REQ-024 n_rst asserted at pixel 1000 -> all outputs 0 immediately; a new start produces a full 262144-write frame from address 0.

Source files
------------

// File: rtl/canny_pkg.sv
// Shared types and constants for the Canny-style edge detector.
package canny_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int IMG_W_DEF = 512;
  localparam int IMG_H_DEF = 512;

  localparam int PIX_W   = 8;
  localparam int GRAD_W  = 11;
  localparam int MAG_W   = 11;
  localparam int ADDR_W  = 19;
  localparam int WADDR_W = 18;

  localparam logic [MAG_W-1:0] THRESH_DEF = 11'd100;

  // Absolute value of a signed gradient. |g| never exceeds 1020, so it fits MAG_W.
  function automatic logic [MAG_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
    logic signed [GRAD_W-1:0] neg;
    neg = -g;
    return g[GRAD_W-1] ? MAG_W'($unsigned(neg)) : MAG_W'($unsigned(g));
  endfunction

endpackage

// File: rtl/canny_edge_sobel_3x3.sv
// Combinational Sobel operator over a 3x3 window (a b c / d e f / g h i).
module sobel_3x3
  import canny_pkg::*;
(
  input  logic        [PIX_W-1:0]  a,
  input  logic        [PIX_W-1:0]  b,
  input  logic        [PIX_W-1:0]  c,
  input  logic        [PIX_W-1:0]  d,
  input  logic        [PIX_W-1:0]  e,
  input  logic        [PIX_W-1:0]  f,
  input  logic        [PIX_W-1:0]  g,
  input  logic        [PIX_W-1:0]  h,
  input  logic        [PIX_W-1:0]  i,
  output logic signed [GRAD_W-1:0] gx,
  output logic signed [GRAD_W-1:0] gy
);

  // Zero-extend an unsigned pixel into the signed gradient width.
  function automatic logic signed [GRAD_W-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({{(GRAD_W-PIX_W){1'b0}}, p});
  endfunction

  logic unused_centre;
  assign unused_centre = ^e;

  // Horizontal and vertical gradients; the centre pixel has zero weight.
  always_comb begin
    gx = (ext(c) + (ext(f) <<< 1) + ext(i)) - (ext(a) + (ext(d) <<< 1) + ext(g));
    gy = (ext(g) + (ext(h) <<< 1) + ext(i)) - (ext(a) + (ext(b) <<< 1) + ext(c));
  end

endmodule

// File: rtl/canny_edge.sv
// Streaming edge detector: walks the frame in row-major order, fetches a 3x3
// window per pixel from nine read SRAMs and writes a thresholded Sobel
// magnitude four cycles later.
module canny_edge
  import canny_pkg::*;
#(
  parameter int               IMG_W  = IMG_W_DEF,
  parameter int               IMG_H  = IMG_H_DEF,
  parameter logic [MAG_W-1:0] THRESH = THRESH_DEF
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  output logic               error,
  output logic               read_enable_r,
  input  logic               mem_init_r,
  output logic [ADDR_W-1:0]  add_a,
  output logic [ADDR_W-1:0]  add_b,
  output logic [ADDR_W-1:0]  add_c,
  output logic [ADDR_W-1:0]  add_d,
  output logic [ADDR_W-1:0]  add_e,
  output logic [ADDR_W-1:0]  add_f,
  output logic [ADDR_W-1:0]  add_g,
  output logic [ADDR_W-1:0]  add_h,
  output logic [ADDR_W-1:0]  add_i,
  input  logic [PIX_W-1:0]   read_a,
  input  logic [PIX_W-1:0]   read_b,
  input  logic [PIX_W-1:0]   read_c,
  input  logic [PIX_W-1:0]   read_d,
  input  logic [PIX_W-1:0]   read_e,
  input  logic [PIX_W-1:0]   read_f,
  input  logic [PIX_W-1:0]   read_g,
  input  logic [PIX_W-1:0]   read_h,
  input  logic [PIX_W-1:0]   read_i,
  output logic               write_enable_w,
  output logic               mem_clr_w,
  input  logic               mem_dump_w,
  output logic [WADDR_W-1:0] write_address,
  output logic [PIX_W-1:0]   write_data
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0]     COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0]     ROW_MAX = RW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] W_ADDR  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  state_t state, next_state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [1:0]    flush_cnt;
  logic          in_frame;
  logic          last_pix;
  logic          border0;
  logic [ADDR_W-1:0] centre;

  logic [PIX_W-1:0]   s1_pix [9];
  logic [WADDR_W-1:0] s1_addr, s2_addr, s3_addr;
  logic               s1_border, s2_border, s3_border;
  logic               s1_valid, s2_valid, s3_valid;
  logic signed [GRAD_W-1:0] gx, gy, s2_gx, s2_gy;
  logic [MAG_W-1:0]   s3_mag;

  assign mem_clr_w = 1'b0;
  assign centre    = ADDR_W'(row) * W_ADDR + ADDR_W'(col);
  assign border0   = (row == '0) || (row == ROW_MAX) || (col == '0) || (col == COL_MAX);
  assign last_pix  = read_enable_r && (row == ROW_MAX) && (col == COL_MAX);

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; DONE waits for start to drop so a held start launches one frame.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start)             next_state = RUN;
      RUN:     if (last_pix)          next_state = FLUSH;
      FLUSH:   if (flush_cnt == 2'd3) next_state = DONE;
      DONE:    if (!start)            next_state = IDLE;
      default:                        next_state = IDLE;
    endcase
  end

  // State-decoded outputs: reads only while issuing, frame window covers the drain.
  always_comb begin
    read_enable_r = 1'b0;
    in_frame      = 1'b0;
    unique case (state)
      RUN:     begin read_enable_r = 1'b1; in_frame = 1'b1; end
      FLUSH:   in_frame = 1'b1;
      default: ;
    endcase
  end

  // Row/column scan counters, parked at (0,0) whenever no pixel is being issued.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      col <= '0;
      row <= '0;
    end else if (read_enable_r) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end else begin
      col <= '0;
      row <= '0;
    end
  end

  // Counts the four drain cycles after the last pixel is issued.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                flush_cnt <= 2'd0;
    else if (state == FLUSH)   flush_cnt <= flush_cnt + 2'd1;
    else                       flush_cnt <= 2'd0;
  end

  // Window addresses; border centres collapse every tap onto the centre address.
  always_comb begin
    add_a = '0; add_b = '0; add_c = '0;
    add_d = '0; add_e = '0; add_f = '0;
    add_g = '0; add_h = '0; add_i = '0;
    if (read_enable_r) begin
      add_e = centre;
      if (border0) begin
        add_a = centre; add_b = centre; add_c = centre;
        add_d = centre; add_f = centre;
        add_g = centre; add_h = centre; add_i = centre;
      end else begin
        add_a = centre - W_ADDR - ONE;
        add_b = centre - W_ADDR;
        add_c = centre - W_ADDR + ONE;
        add_d = centre - ONE;
        add_f = centre + ONE;
        add_g = centre + W_ADDR - ONE;
        add_h = centre + W_ADDR;
        add_i = centre + W_ADDR + ONE;
      end
    end
  end

  // Stage 1: capture the window pixels with their centre address and border flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_pix    <= '{default: '0};
      s1_addr   <= '0;
      s1_border <= 1'b0;
      s1_valid  <= 1'b0;
    end else begin
      s1_valid <= read_enable_r;
      if (read_enable_r) begin
        s1_pix    <= '{read_a, read_b, read_c, read_d, read_e, read_f, read_g, read_h, read_i};
        s1_addr   <= centre[WADDR_W-1:0];
        s1_border <= border0;
      end else begin
        s1_pix    <= '{default: '0};
        s1_addr   <= '0;
        s1_border <= 1'b0;
      end
    end
  end

  sobel_3x3 u_sobel (
    .a (s1_pix[0]), .b (s1_pix[1]), .c (s1_pix[2]),
    .d (s1_pix[3]), .e (s1_pix[4]), .f (s1_pix[5]),
    .g (s1_pix[6]), .h (s1_pix[7]), .i (s1_pix[8]),
    .gx(gx),
    .gy(gy)
  );

  // Stage 2: register the signed gradients.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s2_gx     <= '0;
      s2_gy     <= '0;
      s2_addr   <= '0;
      s2_border <= 1'b0;
      s2_valid  <= 1'b0;
    end else begin
      s2_gx     <= gx;
      s2_gy     <= gy;
      s2_addr   <= s1_addr;
      s2_border <= s1_border;
      s2_valid  <= s1_valid;
    end
  end

  // Stage 3: L1 gradient magnitude, at most 2040 so no overflow in 11 bits.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s3_mag    <= '0;
      s3_addr   <= '0;
      s3_border <= 1'b0;
      s3_valid  <= 1'b0;
    end else begin
      s3_mag    <= abs_grad(s2_gx) + abs_grad(s2_gy);
      s3_addr   <= s2_addr;
      s3_border <= s2_border;
      s3_valid  <= s2_valid;
    end
  end

  // Stage 4: threshold and drive the write port; border pixels are never edges.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      write_enable_w <= 1'b0;
      write_address  <= '0;
      write_data     <= '0;
    end else begin
      write_enable_w <= s3_valid;
      write_address  <= s3_addr;
      write_data     <= (s3_valid && !s3_border && (s3_mag >= THRESH)) ? 8'hFF : 8'h00;
    end
  end

  // Sticky flag for host SRAM access while a frame is in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                                    error <= 1'b0;
    else if (in_frame && (mem_dump_w || mem_init_r)) error <= 1'b1;
  end

endmodule

// File: tb/tb_canny_edge.sv
// Directed bench for canny_edge on a reduced 16x8 frame with combinational SRAM models.
module tb_canny_edge;

  localparam int W = 16;
  localparam int H = 8;
  localparam int N = W * H;
  localparam int TH = 100;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic        error;
  logic        read_enable_r;
  logic        mem_init_r;
  logic [18:0] add_a, add_b, add_c, add_d, add_e, add_f, add_g, add_h, add_i;
  logic [7:0]  read_a, read_b, read_c, read_d, read_e, read_f, read_g, read_h, read_i;
  logic        write_enable_w;
  logic        mem_clr_w;
  logic        mem_dump_w;
  logic [17:0] write_address;
  logic [7:0]  write_data;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int pat        = 0;
  int kval       = 0;
  int rd_count   = 0;
  int wr_count   = 0;
  int run_seen   = 0;
  int run_cyc    = 0;
  int first_wr_cyc = -1;
  int last_wr_cyc  = -1;

  canny_edge #(.IMG_W(W), .IMG_H(H), .THRESH(11'd100)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .start         (start),
    .error         (error),
    .read_enable_r (read_enable_r),
    .mem_init_r    (mem_init_r),
    .add_a         (add_a),
    .add_b         (add_b),
    .add_c         (add_c),
    .add_d         (add_d),
    .add_e         (add_e),
    .add_f         (add_f),
    .add_g         (add_g),
    .add_h         (add_h),
    .add_i         (add_i),
    .read_a        (read_a),
    .read_b        (read_b),
    .read_c        (read_c),
    .read_d        (read_d),
    .read_e        (read_e),
    .read_f        (read_f),
    .read_g        (read_g),
    .read_h        (read_h),
    .read_i        (read_i),
    .write_enable_w(write_enable_w),
    .mem_clr_w     (mem_clr_w),
    .mem_dump_w    (mem_dump_w),
    .write_address (write_address),
    .write_data    (write_data)
  );

  // 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising-edge counter used to measure latency.
  always @(posedge clk) cyc++;

  // Image content as a function of address: 0 uniform 128, 1 vertical step, 2 horizontal step.
  function automatic logic [7:0] pix(input logic [18:0] a, input int p, input int k);
    int idx, r, c;
    idx = int'(a);
    if (idx >= N) return 8'h00;
    r = idx / W;
    c = idx % W;
    case (p)
      1:       return (c >= W / 2) ? 8'(k) : 8'h00;
      2:       return (r >= H / 2) ? 8'(k) : 8'h00;
      default: return 8'd128;
    endcase
  endfunction

  assign read_a = pix(add_a, pat, kval);
  assign read_b = pix(add_b, pat, kval);
  assign read_c = pix(add_c, pat, kval);
  assign read_d = pix(add_d, pat, kval);
  assign read_e = pix(add_e, pat, kval);
  assign read_f = pix(add_f, pat, kval);
  assign read_g = pix(add_g, pat, kval);
  assign read_h = pix(add_h, pat, kval);
  assign read_i = pix(add_i, pat, kval);

  // Hand-derived edge map: a step of height k gives |G| = 4k on the two columns/rows either side.
  function automatic logic [7:0] exp_out(input int idx);
    int r, c;
    r = idx / W;
    c = idx % W;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'h00;
    case (pat)
      1:       return ((c == W / 2 - 1 || c == W / 2) && 4 * kval >= TH) ? 8'hFF : 8'h00;
      2:       return ((r == H / 2 - 1 || r == H / 2) && 4 * kval >= TH) ? 8'hFF : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Window addresses of the idx-th issued centre.
  task automatic checkWindow(input int idx);
    int r, c;
    logic [31:0] got [9];
    int          want [9];
    r = idx / W;
    c = idx % W;
    got = '{32'(add_a), 32'(add_b), 32'(add_c), 32'(add_d), 32'(add_e),
            32'(add_f), 32'(add_g), 32'(add_h), 32'(add_i)};
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) begin
      for (int k = 0; k < 9; k++) want[k] = idx;
    end else begin
      want = '{idx - W - 1, idx - W, idx - W + 1, idx - 1, idx,
               idx + 1, idx + W - 1, idx + W, idx + W + 1};
    end
    for (int k = 0; k < 9; k++)
      checkOutput($sformatf("win%0d_px%0d", k, idx), got[k], 32'(want[k]));
  endtask

  // Monitor on the falling edge: checks every issued window and every write.
  always @(negedge clk) begin
    if (!n_rst) begin
      rd_count     = 0;
      wr_count     = 0;
      run_seen     = 0;
      first_wr_cyc = -1;
      last_wr_cyc  = -1;
    end else begin
      if (read_enable_r) begin
        if (run_seen == 0) begin
          run_seen = 1;
          run_cyc  = cyc;
        end
        checkWindow(rd_count);
        rd_count++;
      end
      if (write_enable_w) begin
        if (wr_count == 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        checkOutput("wr_addr", 32'(write_address), 32'(wr_count));
        checkOutput("wr_data", 32'(write_data), 32'(exp_out(wr_count)));
        wr_count++;
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ctl"}, 32'({error, read_enable_r, write_enable_w, mem_clr_w}), 32'd0);
    checkOutput({tag, "_adds"}, 32'(|{add_a, add_b, add_c, add_d, add_e, add_f, add_g, add_h, add_i}), 32'd0);
    checkOutput({tag, "_waddr"}, 32'(write_address), 32'd0);
    checkOutput({tag, "_wdata"}, 32'(write_data), 32'd0);
  endtask

  // Asserts reset between clock edges and checks outputs clear immediately.
  task automatic doReset();
    @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    checkResetOutputs("rst");
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  // Runs one frame with start held for start_len cycles, then checks frame totals and latency.
  task automatic applyStimulus(input int p, input int k, input int start_len);
    pat   = p;
    kval  = k;
    start = 1'b1;
    repeat (start_len) @(negedge clk);
    start = 1'b0;
    repeat (N + 20) @(negedge clk);
    checkOutput($sformatf("frame_writes_p%0d_k%0d", p, k), 32'(wr_count), 32'(N));
    checkOutput($sformatf("frame_issues_p%0d_k%0d", p, k), 32'(rd_count), 32'(N));
    checkOutput("first_latency", 32'(first_wr_cyc - run_cyc), 32'd4);
    checkOutput("last_latency", 32'(last_wr_cyc - run_cyc), 32'(N + 3));
    checkOutput("frame_error", 32'(error), 32'd0);
    checkOutput("idle_we", 32'(write_enable_w), 32'd0);
    checkOutput("idle_re", 32'(read_enable_r), 32'd0);
  endtask

  // Directed sequence.
  initial begin
    n_rst      = 1'b0;
    start      = 1'b0;
    mem_init_r = 1'b0;
    mem_dump_w = 1'b0;
    $display("[TB] start, frame %0dx%0d", W, H);

    doReset();

    mem_init_r = 1'b1;
    repeat (3) @(negedge clk);
    mem_init_r = 1'b0;
    @(negedge clk);
    checkOutput("idle_init_no_err", 32'(error), 32'd0);

    applyStimulus(0, 128, 3);
    doReset();
    applyStimulus(1, 255, 3);
    doReset();
    applyStimulus(1, 25, 1);
    doReset();
    applyStimulus(1, 24, 1);
    doReset();
    applyStimulus(2, 25, N + 30);
    doReset();
    applyStimulus(2, 255, 2);

    // Host dump during RUN sets the sticky error flag.
    doReset();
    pat   = 0;
    kval  = 128;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < N + 10; n++) begin
      if (rd_count >= 40) break;
      @(negedge clk);
    end
    checkOutput("err_wait_run", 32'(rd_count >= 40), 32'd1);
    checkOutput("err_pre", 32'(error), 32'd0);
    mem_dump_w = 1'b1;
    @(negedge clk);
    mem_dump_w = 1'b0;
    checkOutput("err_rise", 32'(error), 32'd1);
    repeat (N + 20) @(negedge clk);
    checkOutput("err_sticky", 32'(error), 32'd1);
    checkOutput("err_frame_writes", 32'(wr_count), 32'(N));
    doReset();

    // Host init during FLUSH also sets the flag.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < N + 10; n++) begin
      if (rd_count >= N) break;
      @(negedge clk);
    end
    @(negedge clk);
    checkOutput("flush_reached_re", 32'(read_enable_r), 32'd0);
    mem_init_r = 1'b1;
    @(negedge clk);
    mem_init_r = 1'b0;
    checkOutput("err_flush_init", 32'(error), 32'd1);
    repeat (20) @(negedge clk);
    doReset();

    // Reset mid-frame aborts writes; the following frame restarts from address 0.
    pat   = 1;
    kval  = 255;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < N + 10; n++) begin
      if (rd_count >= 60) break;
      @(negedge clk);
    end
    checkOutput("abort_reached", 32'(rd_count >= 60), 32'd1);
    #2;
    n_rst = 1'b0;
    #1;
    checkResetOutputs("abort");
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checkOutput("abort_no_write", 32'(write_enable_w), 32'd0);
    end
    n_rst = 1'b1;
    @(negedge clk);
    applyStimulus(1, 255, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
